fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. It sits directly upstream of the hazard detection unit. It owns the PC and issues requests to a variable-latency instruction memory. It delivers instructions to ID and obeys the hazard unit's load-use stall, halt PC-stall, and the MEM-stage branch-taken redirect.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset
NOP_INST, 16'h0000, instruction word driven into IF/ID for a bubble

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
branch_taken  input  1  branch taken in MEM; redirect PC this cycle
branch_target  input  16  redirect address, valid with branch_taken
loaduse_stall  input  1  hold PC and IF/ID (from hazard unit)
halt_stall_pc  input  1  stop fetching beyond halt (from hazard unit)
imem_req  output  1  instruction read request
imem_addr  output  16  request address
imem_rdata  input  16  read data, valid with imem_valid
imem_valid  input  1  one-cycle completion pulse for the outstanding request
ifid_inst  output  16  instruction to ID
ifid_pc_plus2  output  16  PC+2 of ifid_inst
ifid_valid  output  1  ifid_inst is a real instruction
fetch_busy  output  1  request outstanding and no data yet (debug/perf)

Behaviour:
- Memory protocol: once imem_req=1, imem_addr and imem_req hold stable until imem_valid. Requests are non-abortable. At most one request is outstanding. imem_valid without imem_req is ignored.
- State machine: FETCH, DRAIN, HALT.
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, ifid_inst=NOP_INST, ifid_pc_plus2=0, ifid_valid=0, skid empty, imem_req=0. imem_req rises the first cycle after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc.
- Per-cycle priority: branch_taken > loaduse_stall > halt_stall_pc > normal.
- Normal delivery: on imem_valid, IF/ID loads {imem_rdata, pc+2, valid=1} at the next edge and pc<=pc+2. A new request issues in the following cycle. Latency is imem_valid to ifid_valid in 1 cycle, so a zero-wait memory sustains 1 instruction every 2 cycles. Cycles with no delivery load a bubble (NOP_INST, valid=0).
- branch_taken:
  - IF/ID loads a bubble and the skid is cleared.
  - If no request is outstanding, or imem_valid arrives the same cycle: pc<=branch_target, state FETCH, and the data is discarded.
  - If a request is outstanding without imem_valid: latch branch_target into redirect_pc and enter DRAIN.
- DRAIN: imem_req stays held. On imem_valid, discard the data, pc<=redirect_pc, go to FETCH. A further branch_taken in DRAIN overwrites redirect_pc.
- loaduse_stall: IF/ID and pc hold. If imem_valid arrives while stalled, the data goes into a 1-entry skid {inst, pc+2}, pc<=pc+2, and no new request issues while the skid is full. When the stall drops, IF/ID loads from the skid, the skid clears, and fetching resumes. An empty skid gives a normal bubble.
- halt_stall_pc: no new request issues. An outstanding request completes and its data is discarded (IF/ID gets a bubble), and pc does not advance. A held skid entry is discarded. Enter HALT when nothing is outstanding.
- HALT: imem_req=0, IF/ID bubble. Exit to FETCH when halt_stall_pc=0, resuming at the held pc. branch_taken in HALT redirects immediately to FETCH at branch_target.
- Arithmetic: pc+2 is modulo 2^16 (16'hFFFE+2=16'h0000). branch_target bit 0 is ignored (forced 0).
- fetch_busy = imem_req & ~imem_valid.
- Reset mid-operation: all state clears immediately. Any in-flight memory response arriving after reset is ignored because imem_req=0.

Test Plan:
- Reset/straight-line: rst low 3 cycles, zero-wait memory returning addr-as-data. Required: imem_addr 0,2,4,6; ifid_inst 0000,0002,0004 with ifid_pc_plus2 2,4,6; ifid_valid=0 before the first delivery.
- Wait states: memory latency 3 cycles. Required: imem_addr held 3 cycles per request; fetch_busy=1 for 2 cycles each; no duplicate or lost instruction.
- Load-use + skid: assert loaduse_stall 2 cycles while imem_valid returns 0x1234 at pc 0x10. Required: IF/ID holds its prior value during the stall, then shows 0x1234/0x12 the cycle after release; no second request to 0x10.
- Branch during outstanding request: request at 0x20 pending, branch_taken with target 0x0100, imem_valid 2 cycles later. Required: state DRAIN, data from 0x20 never reaches IF/ID, next imem_addr=0x0100.
- Halt then redirect: halt_stall_pc held high. Required: imem_req=0 after the outstanding access, IF/ID bubbles. Then branch_taken with target 0x0040: fetch resumes at 0x0040.
- Wrap/reset mid-op: pc at 0xFFFE, next address 0x0000. Assert rst during an outstanding request: outputs return to reset values asynchronously and a late imem_valid is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory and drives the IF/ID register. It handles load-use stall, halt and branch redirect.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        loaduse_stall,
   input  logic        halt_stall_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic [15:0] ifid_inst,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [15:0] r_redirect_pc, w_redirect_nxt;
   logic        r_req, w_req_nxt;
   logic        r_skid_valid, w_skid_valid_nxt;
   logic [15:0] r_skid_inst, w_skid_inst_nxt;
   logic [15:0] r_skid_pc2, w_skid_pc2_nxt;
   logic [15:0] r_ifid_inst, w_ifid_inst_nxt;
   logic [15:0] r_ifid_pc2, w_ifid_pc2_nxt;
   logic        r_ifid_valid, w_ifid_valid_nxt;
   logic        w_done;
   logic [15:0] w_pc_plus2;
   logic [15:0] w_target;

   // r_req doubles as the "request outstanding" flag, so address and request stay put until imem_valid
   assign w_done        = r_req & imem_valid;
   assign w_pc_plus2    = r_pc + 16'd2;
   assign w_target      = {branch_target[15:1], 1'b0};
   assign imem_req      = r_req;
   assign imem_addr     = r_pc;
   assign fetch_busy    = r_req & ~imem_valid;
   assign ifid_inst     = r_ifid_inst;
   assign ifid_pc_plus2 = r_ifid_pc2;
   assign ifid_valid    = r_ifid_valid;

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_redirect_nxt   = r_redirect_pc;
      w_req_nxt        = r_req;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_inst_nxt  = r_skid_inst;
      w_skid_pc2_nxt   = r_skid_pc2;
      w_ifid_inst_nxt  = loaduse_stall ? r_ifid_inst : NOP_INST;
      w_ifid_pc2_nxt   = r_ifid_pc2;
      w_ifid_valid_nxt = loaduse_stall ? r_ifid_valid : 1'b0;

      if (branch_taken) begin
         w_ifid_inst_nxt  = NOP_INST;
         w_ifid_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
         if (!r_req || imem_valid) begin
            w_pc_nxt    = w_target;
            w_state_nxt = FETCH;
            w_req_nxt   = 1'b0;
         end else begin
            w_redirect_nxt = w_target;
            w_state_nxt    = DRAIN;
         end
      end else begin
         case (r_state)
            DRAIN: begin
               if (w_done) begin
                  w_pc_nxt    = r_redirect_pc;
                  w_state_nxt = FETCH;
                  w_req_nxt   = 1'b0;
               end
            end
            HALT: begin
               if (!halt_stall_pc) begin
                  w_state_nxt = FETCH;
               end
            end
            default: begin
               if (loaduse_stall) begin
                  if (w_done) begin
                     w_skid_valid_nxt = 1'b1;
                     w_skid_inst_nxt  = imem_rdata;
                     w_skid_pc2_nxt   = w_pc_plus2;
                     w_pc_nxt         = w_pc_plus2;
                     w_req_nxt        = 1'b0;
                  end else if (!r_req && !r_skid_valid) begin
                     w_req_nxt = 1'b1;
                  end
               end else if (halt_stall_pc) begin
                  // Let the outstanding access finish, but throw away its data and any skid entry
                  w_skid_valid_nxt = 1'b0;
                  if (!r_req || imem_valid) begin
                     w_state_nxt = HALT;
                     w_req_nxt   = 1'b0;
                  end
               end else if (r_skid_valid) begin
                  w_ifid_inst_nxt  = r_skid_inst;
                  w_ifid_pc2_nxt   = r_skid_pc2;
                  w_ifid_valid_nxt = 1'b1;
                  w_skid_valid_nxt = 1'b0;
                  w_req_nxt        = 1'b1;
               end else if (w_done) begin
                  w_ifid_inst_nxt  = imem_rdata;
                  w_ifid_pc2_nxt   = w_pc_plus2;
                  w_ifid_valid_nxt = 1'b1;
                  w_pc_nxt         = w_pc_plus2;
                  w_req_nxt        = 1'b0;
               end else if (!r_req) begin
                  w_req_nxt = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_redirect_pc <= RESET_PC;
         r_req         <= 1'b0;
         r_skid_valid  <= 1'b0;
         r_skid_inst   <= NOP_INST;
         r_skid_pc2    <= 16'h0000;
         r_ifid_inst   <= NOP_INST;
         r_ifid_pc2    <= 16'h0000;
         r_ifid_valid  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_redirect_pc <= w_redirect_nxt;
         r_req         <= w_req_nxt;
         r_skid_valid  <= w_skid_valid_nxt;
         r_skid_inst   <= w_skid_inst_nxt;
         r_skid_pc2    <= w_skid_pc2_nxt;
         r_ifid_inst   <= w_ifid_inst_nxt;
         r_ifid_pc2    <= w_ifid_pc2_nxt;
         r_ifid_valid  <= w_ifid_valid_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a simple variable-latency memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        branchTaken = 1'b0;
   logic [15:0] branchTarget = 16'h0000;
   logic        loadUseStall = 1'b0;
   logic        haltStallPc = 1'b0;
   logic        imemReq;
   logic [15:0] imemAddr;
   logic [15:0] imemRdata;
   logic        imemValid;
   logic [15:0] ifidInst;
   logic [15:0] ifidPcPlus2;
   logic        ifidValid;
   logic        fetchBusy;

   logic        memAuto = 1'b1;
   int          memLatency = 1;
   int          memCount = 0;
   logic        autoValid = 1'b0;
   logic [15:0] autoData = 16'h0000;
   logic        forceValid = 1'b0;
   logic [15:0] forceData = 16'h0000;

   int testCount = 0;
   int failCount = 0;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .branch_taken (branchTaken),
      .branch_target(branchTarget),
      .loaduse_stall(loadUseStall),
      .halt_stall_pc(haltStallPc),
      .imem_req     (imemReq),
      .imem_addr    (imemAddr),
      .imem_rdata   (imemRdata),
      .imem_valid   (imemValid),
      .ifid_inst    (ifidInst),
      .ifid_pc_plus2(ifidPcPlus2),
      .ifid_valid   (ifidValid),
      .fetch_busy   (fetchBusy)
   );

   always #5 clk = ~clk;

   assign imemValid = memAuto ? autoValid : forceValid;
   assign imemRdata = memAuto ? autoData : forceData;

   function automatic logic [15:0] memData(input logic [15:0] addr);
      return (addr == 16'h0010) ? 16'h1234 : addr;
   endfunction

   // The memory answers in the memLatency-th cycle a request is held
   always @(negedge clk) begin
      if (memAuto && imemReq) begin
         memCount = memCount + 1;
         if (memCount >= memLatency) begin
            autoValid = 1'b1;
            autoData  = memData(imemAddr);
            memCount  = 0;
         end else begin
            autoValid = 1'b0;
         end
      end else begin
         autoValid = 1'b0;
         memCount  = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives the hazard/branch inputs for one clock edge and returns mid-way through the next cycle
   task automatic applyStimulus(input logic br, input logic [15:0] tgt, input logic lu, input logic hl);
      branchTaken  = br;
      branchTarget = tgt;
      loadUseStall = lu;
      haltStallPc  = hl;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_req", {15'd0, imemReq}, 16'h0000);
      checkOutput("rst_valid", {15'd0, ifidValid}, 16'h0000);
      checkOutput("rst_inst", ifidInst, 16'h0000);
      checkOutput("rst_pc2", ifidPcPlus2, 16'h0000);
      rst = 1'b1;
      idle();
      checkOutput("first_valid", {15'd0, ifidValid}, 16'h0000);
      checkOutput("first_busy", {15'd0, fetchBusy}, 16'h0000);

      // Straight-line, zero-wait memory
      for (int k = 0; k < 3; k++) begin
         checkOutput("sl_req", {15'd0, imemReq}, 16'h0001);
         checkOutput("sl_addr", imemAddr, 16'(2 * k));
         checkOutput("sl_bubble", {15'd0, ifidValid}, 16'h0000);
         idle();
         checkOutput("sl_inst", ifidInst, 16'(2 * k));
         checkOutput("sl_pc2", ifidPcPlus2, 16'(2 * k + 2));
         checkOutput("sl_valid", {15'd0, ifidValid}, 16'h0001);
         checkOutput("sl_gap", {15'd0, imemReq}, 16'h0000);
         idle();
      end
      checkOutput("sl_addr6", imemAddr, 16'h0006);

      // Three-cycle memory latency
      memLatency = 3;
      idle();
      checkOutput("ws_inst6", ifidInst, 16'h0006);
      for (int k = 0; k < 2; k++) begin
         idle();
         checkOutput("ws_addr_c1", imemAddr, 16'(8 + 2 * k));
         checkOutput("ws_busy_c1", {15'd0, fetchBusy}, 16'h0001);
         checkOutput("ws_valid_c1", {15'd0, ifidValid}, 16'h0000);
         idle();
         checkOutput("ws_addr_c2", imemAddr, 16'(8 + 2 * k));
         checkOutput("ws_busy_c2", {15'd0, fetchBusy}, 16'h0001);
         checkOutput("ws_valid_c2", {15'd0, ifidValid}, 16'h0000);
         idle();
         checkOutput("ws_addr_c3", imemAddr, 16'(8 + 2 * k));
         checkOutput("ws_busy_c3", {15'd0, fetchBusy}, 16'h0000);
         idle();
         checkOutput("ws_inst", ifidInst, 16'(8 + 2 * k));
         checkOutput("ws_pc2", ifidPcPlus2, 16'(10 + 2 * k));
         checkOutput("ws_valid", {15'd0, ifidValid}, 16'h0001);
      end

      // Load-use stall with skid capture
      memLatency = 1;
      idle();
      idle();
      idle();
      idle();
      checkOutput("lu_pre_inst", ifidInst, 16'h000E);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("lu_addr", imemAddr, 16'h0010);
      checkOutput("lu_hold1", ifidInst, 16'h000E);
      checkOutput("lu_hold1_v", {15'd0, ifidValid}, 16'h0001);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("lu_hold2", ifidInst, 16'h000E);
      checkOutput("lu_hold2_pc2", ifidPcPlus2, 16'h0010);
      checkOutput("lu_noreq", {15'd0, imemReq}, 16'h0000);
      idle();
      checkOutput("lu_skid_inst", ifidInst, 16'h1234);
      checkOutput("lu_skid_pc2", ifidPcPlus2, 16'h0012);
      checkOutput("lu_skid_v", {15'd0, ifidValid}, 16'h0001);
      checkOutput("lu_next_addr", imemAddr, 16'h0012);
      idle();
      checkOutput("lu_after", ifidInst, 16'h0012);

      // Branch while a request is outstanding
      memLatency = 3;
      applyStimulus(1'b1, 16'h0021, 1'b0, 1'b0);
      checkOutput("br_bubble", {15'd0, ifidValid}, 16'h0000);
      idle();
      checkOutput("br_req20", {15'd0, imemReq}, 16'h0001);
      checkOutput("br_addr20", imemAddr, 16'h0020);
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
      checkOutput("dr_held", imemAddr, 16'h0020);
      checkOutput("dr_busy", {15'd0, fetchBusy}, 16'h0001);
      idle();
      checkOutput("dr_valid_cycle", {15'd0, ifidValid}, 16'h0000);
      idle();
      checkOutput("dr_discard_v", {15'd0, ifidValid}, 16'h0000);
      checkOutput("dr_discard_i", ifidInst, 16'h0000);
      idle();
      checkOutput("dr_new_addr", imemAddr, 16'h0100);
      checkOutput("dr_new_req", {15'd0, imemReq}, 16'h0001);
      idle();
      idle();
      idle();
      checkOutput("dr_inst", ifidInst, 16'h0100);
      checkOutput("dr_pc2", ifidPcPlus2, 16'h0102);

      // Halt with an access in flight, then a redirect out of HALT
      idle();
      checkOutput("ht_addr", imemAddr, 16'h0102);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("ht_req_held", {15'd0, imemReq}, 16'h0001);
      checkOutput("ht_addr_held", imemAddr, 16'h0102);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("ht_bubble1", {15'd0, ifidValid}, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("ht_req_off", {15'd0, imemReq}, 16'h0000);
      checkOutput("ht_discard", {15'd0, ifidValid}, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("ht_req_off2", {15'd0, imemReq}, 16'h0000);
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
      idle();
      checkOutput("ht_resume_req", {15'd0, imemReq}, 16'h0001);
      checkOutput("ht_resume_addr", imemAddr, 16'h0040);
      idle();
      idle();
      idle();
      checkOutput("ht_inst40", ifidInst, 16'h0040);

      // PC wrap, then reset in the middle of an access
      memLatency = 1;
      applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
      idle();
      checkOutput("wr_addr", imemAddr, 16'hFFFE);
      idle();
      checkOutput("wr_inst", ifidInst, 16'hFFFE);
      checkOutput("wr_pc2", ifidPcPlus2, 16'h0000);
      memLatency = 3;
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("wr_next_addr", imemAddr, 16'h0000);
      checkOutput("wr_busy", {15'd0, fetchBusy}, 16'h0001);
      checkOutput("wr_hold", ifidInst, 16'hFFFE);
      memAuto = 1'b0;
      loadUseStall = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("mr_req", {15'd0, imemReq}, 16'h0000);
      checkOutput("mr_valid", {15'd0, ifidValid}, 16'h0000);
      checkOutput("mr_inst", ifidInst, 16'h0000);
      @(negedge clk);
      #1;
      forceValid = 1'b1;
      forceData  = 16'hBEEF;
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      forceValid = 1'b0;
      checkOutput("late_valid", {15'd0, ifidValid}, 16'h0000);
      checkOutput("late_inst", ifidInst, 16'h0000);
      checkOutput("late_req", {15'd0, imemReq}, 16'h0001);
      checkOutput("late_addr", imemAddr, 16'h0000);
      memLatency = 1;
      memAuto = 1'b1;
      idle();
      checkOutput("post_busy", {15'd0, fetchBusy}, 16'h0000);
      idle();
      checkOutput("post_inst", ifidInst, 16'h0000);
      checkOutput("post_pc2", ifidPcPlus2, 16'h0002);
      checkOutput("post_valid", {15'd0, ifidValid}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
